i2c_reg_xfer: RTL and testbench
===============================

I2C_REG_XFER -- requirements
Module: i2c_reg_xfer

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h74, meaning the 7-bit I2C device address.
REQ-002 The block SHALL have parameter PAGE_REG, default 8'h01, meaning the device page-select register.
REQ-003 The block SHALL have port clk_i, input, 1, system clock.
REQ-004 The block SHALL have port arstn_i, input, 1, reset: asynchronous, active-low.
REQ-005 The block SHALL have port req_valid_i, input, 1, register access request valid.
REQ-006 The block SHALL have port req_ready_o, output, 1, request accepted when high together with req_valid_i.
REQ-007 The block SHALL have port req_rw_i, input, 1, 0=write, 1=read.
REQ-008 The block SHALL have port req_addr_i, input, 16, [15:8] page, [7:0] register.
REQ-009 The block SHALL have port req_wdata_i, input, 8, write data.
REQ-010 The block SHALL have port rsp_valid_o, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port rsp_rdata_o, output, 8, read data, held until next response.
REQ-012 The block SHALL have port rsp_err_o, output, 1, NACK seen, valid with rsp_valid_o.
REQ-013 The block SHALL have ports start_o, stop_o, write_o, read_o, ack_in_o (all output, 1) and din_o (output, 8), forming the byte-master command bus.
REQ-014 The block SHALL have ports cmd_ack_i (input, 1), ack_out_i (input, 1, high=slave NACK) and dout_i (input, 8), forming the byte-master status bus.

Function
REQ-015 The block SHALL have req_ready_o high only in IDLE and SHALL capture rw/addr/wdata on a valid&ready cycle.
REQ-016 The block SHALL issue each byte as a one-cycle command pulse, then wait for cmd_ack_i before the next command, with no timeout.
REQ-017 The block SHALL hold din_o stable from its command pulse until cmd_ack_i.
REQ-018 The block SHALL perform a page write when the page differs from the cached page or the cache is invalid: START+{SLAVE_ADDR,0}; PAGE_REG; page+STOP.
REQ-019 The block SHALL perform a register write as START+{SLAVE_ADDR,0}; reg; wdata+STOP.
REQ-020 The block SHALL perform a register read as START+{SLAVE_ADDR,0}; reg; START+{SLAVE_ADDR,1}; READ with ack_in_o=1 (master NACK)+STOP, and SHALL latch dout_i into rsp_rdata_o on that cmd_ack_i.
REQ-021 The block SHALL use states IDLE, PG_SA, PG_REG, PG_DAT, SA, REG, WDAT, RSA, RDAT, ABORT, RESP.
REQ-022 The block SHALL take the transitions: IDLE->PG_SA (page miss) or SA (page hit); PG_DAT->SA; REG->WDAT or RSA; WDAT/RDAT->RESP; RESP->IDLE.
REQ-023 The block SHALL go to ABORT when ack_out_i=1 on the cmd_ack_i of any write-type byte, SHALL issue a stop-only command, and after its cmd_ack_i SHALL go to RESP with rsp_err_o=1 and clear the page-cache valid flag.
REQ-024 The block SHALL update the cached page and set valid only after PG_DAT completes with ACK.
REQ-025 The block SHALL drive rsp_valid_o for exactly one cycle in RESP; a new request is acceptable in the following cycle.
REQ-026 The block SHALL ignore a cmd_ack_i arriving while no command is outstanding.

Reset
REQ-027 On arstn_i low the block SHALL go to IDLE, clear page-cache valid, and drive all command outputs, rsp_valid_o and rsp_err_o to 0 and din_o and rsp_rdata_o to 8'h00.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer without issuing a STOP; the byte master is reset on the same arstn_i.

Structure
REQ-029 The state enum, rw_e (WRITE=0, READ=1), default SLAVE_ADDR and PAGE_REG SHALL live in cfg_pkg.
REQ-030 The block SHALL be a single module with no sub-modules; it instantiates nothing and sits between the config loader and i2c_master_byte.

Verification
REQ-031 The bench SHALL check: after reset, write 0x0B24=0x5A -> bytes E8,01,0B(stop), E8,24,5A(stop); rsp_valid_o=1, rsp_err_o=0.
REQ-032 The bench SHALL check: write 0x0B25=0x11 following REQ-031 -> page skipped; bytes E8,25,11 only.
REQ-033 The bench SHALL check: read 0x0B02 with model returning 0x34 -> E8,02, restart E9, READ ack_in_o=1+stop; rsp_rdata_o=0x34.
REQ-034 The bench SHALL check: NACK on the register byte -> stop-only command, rsp_err_o=1; the next access to page 0x0B rewrites the page.
REQ-035 The bench SHALL check: arstn_i pulsed low during WDAT -> all outputs 0 within the reset; the next request performs a page write.
REQ-036 The bench SHALL check: back-to-back requests held valid -> second accepted the cycle after the first's rsp_valid_o; req_ready_o=0 throughout the transfer.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared configuration for the I2C register-transfer engine: FSM state
// encoding, access direction and default device addressing.
package cfg_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    PG_SA  = 4'd1,
    PG_REG = 4'd2,
    PG_DAT = 4'd3,
    SA     = 4'd4,
    REG    = 4'd5,
    WDAT   = 4'd6,
    RSA    = 4'd7,
    RDAT   = 4'd8,
    ABORT  = 4'd9,
    RESP   = 4'd10
  } state_e;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } rw_e;

  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h74;
  localparam logic [7:0] DEF_PAGE_REG   = 8'h01;

  // Address byte on the wire: 7-bit device address followed by the R/W bit.
  function automatic logic [7:0] addr_byte(input logic [6:0] sa, input rw_e rw);
    return {sa, rw};
  endfunction

endpackage

// File: rtl/i2c_reg_xfer.sv
// Paged register access over an I2C byte master: caches the device page,
// sequences START/address/register/data bytes and reports NACK as an error.
module i2c_reg_xfer
  import cfg_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter logic [7:0] PAGE_REG   = DEF_PAGE_REG
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rw_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        start_o,
  output logic        stop_o,
  output logic        write_o,
  output logic        read_o,
  output logic        ack_in_o,
  output logic [7:0]  din_o,
  input  logic        cmd_ack_i,
  input  logic        ack_out_i,
  input  logic [7:0]  dout_i
);

  state_e      r_state;
  state_e      w_state_next;
  logic        r_issued;
  rw_e         r_rw;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_page;
  logic        r_page_vld;
  logic        r_err;
  logic [7:0]  r_rdata;

  logic        w_accept;
  logic        w_page_hit;
  logic        w_byte_state;
  logic        w_write_byte;
  logic        w_issue;
  logic        w_done;
  logic        w_nack;

  assign w_accept     = (r_state == IDLE) && req_valid_i;
  assign w_page_hit   = r_page_vld && (req_addr_i[15:8] == r_page);
  assign w_byte_state = r_state inside {PG_SA, PG_REG, PG_DAT, SA, REG, WDAT, RSA, RDAT, ABORT};
  assign w_write_byte = r_state inside {PG_SA, PG_REG, PG_DAT, SA, REG, WDAT, RSA};
  // A byte state pulses its command on entry, then only an ack after the pulse counts.
  assign w_issue      = w_byte_state && !r_issued;
  assign w_done       = w_byte_state && r_issued && cmd_ack_i;
  assign w_nack       = w_done && w_write_byte && ack_out_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_page_hit ? SA : PG_SA;
      PG_SA:   if (w_done) w_state_next = PG_REG;
      PG_REG:  if (w_done) w_state_next = PG_DAT;
      PG_DAT:  if (w_done) w_state_next = SA;
      SA:      if (w_done) w_state_next = REG;
      REG:     if (w_done) w_state_next = (r_rw == READ) ? RSA : WDAT;
      WDAT:    if (w_done) w_state_next = RESP;
      RSA:     if (w_done) w_state_next = RDAT;
      RDAT:    if (w_done) w_state_next = RESP;
      ABORT:   if (w_done) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (w_nack) begin
      w_state_next = ABORT;
    end
  end

  always_comb begin
    start_o  = 1'b0;
    stop_o   = 1'b0;
    write_o  = 1'b0;
    read_o   = 1'b0;
    ack_in_o = 1'b0;
    din_o    = 8'h00;
    case (r_state)
      PG_SA: begin
        start_o = w_issue;
        write_o = w_issue;
        din_o   = addr_byte(SLAVE_ADDR, WRITE);
      end
      PG_REG: begin
        write_o = w_issue;
        din_o   = PAGE_REG;
      end
      PG_DAT: begin
        write_o = w_issue;
        stop_o  = w_issue;
        din_o   = r_addr[15:8];
      end
      SA: begin
        start_o = w_issue;
        write_o = w_issue;
        din_o   = addr_byte(SLAVE_ADDR, WRITE);
      end
      REG: begin
        write_o = w_issue;
        din_o   = r_addr[7:0];
      end
      WDAT: begin
        write_o = w_issue;
        stop_o  = w_issue;
        din_o   = r_wdata;
      end
      RSA: begin
        start_o = w_issue;
        write_o = w_issue;
        din_o   = addr_byte(SLAVE_ADDR, READ);
      end
      // Single-byte read: master NACKs the byte and closes the bus.
      RDAT: begin
        read_o   = w_issue;
        ack_in_o = w_issue;
        stop_o   = w_issue;
      end
      ABORT: begin
        stop_o = w_issue;
      end
      default: ;
    endcase
  end

  assign req_ready_o = (r_state == IDLE);
  assign rsp_valid_o = (r_state == RESP);
  assign rsp_err_o   = (r_state == RESP) && r_err;
  assign rsp_rdata_o = r_rdata;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_issued <= 1'b0;
    end else if (w_issue) begin
      r_issued <= 1'b1;
    end else if (w_done) begin
      r_issued <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_rw    <= WRITE;
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rw    <= rw_e'(req_rw_i);
      r_addr  <= req_addr_i;
      r_wdata <= req_wdata_i;
      r_err   <= 1'b0;
    end else if (w_nack) begin
      r_err   <= 1'b1;
    end
  end

  // The cache only becomes valid once the device has acknowledged the page byte.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_page     <= 8'h00;
      r_page_vld <= 1'b0;
    end else if (w_done && (r_state == PG_DAT) && !ack_out_i) begin
      r_page     <= r_addr[15:8];
      r_page_vld <= 1'b1;
    end else if (w_done && (r_state == ABORT)) begin
      r_page_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_rdata <= 8'h00;
    end else if (w_done && (r_state == RDAT)) begin
      r_rdata <= dout_i;
    end
  end

endmodule

// File: tb/tb_i2c_reg_xfer.sv
// Scoreboarded bench for i2c_reg_xfer with a behavioural byte-master model
// that acknowledges commands after a random latency and can inject a NACK.
module tb_i2c_reg_xfer;

  localparam logic [7:0] SA_W = 8'hE8;
  localparam logic [7:0] SA_R = 8'hE9;
  localparam logic [7:0] PGR  = 8'h01;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_rw_i;
  logic [15:0] req_addr_i;
  logic [7:0]  req_wdata_i;
  logic        rsp_valid_o;
  logic [7:0]  rsp_rdata_o;
  logic        rsp_err_o;
  logic        start_o, stop_o, write_o, read_o, ack_in_o;
  logic [7:0]  din_o;
  logic        cmd_ack_i;
  logic        ack_out_i;
  logic [7:0]  dout_i;

  i2c_reg_xfer dut (
    .clk_i       (clk_i),
    .arstn_i     (arstn_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_rw_i    (req_rw_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .start_o     (start_o),
    .stop_o      (stop_o),
    .write_o     (write_o),
    .read_o      (read_o),
    .ack_in_o    (ack_in_o),
    .din_o       (din_o),
    .cmd_ack_i   (cmd_ack_i),
    .ack_out_i   (ack_out_i),
    .dout_i      (dout_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Command record: {start, stop, write, read, ack_in, din}
  logic [12:0] cmd_q[$];
  // Response record: {err, is_read, rdata}
  logic [9:0]  rsp_q[$];

  logic [7:0]  rd_val   = 8'h00;
  logic [7:0]  nack_din = 8'h00;
  int          nack_req = 0;
  int          stray_req = 0;
  logic        m_vld    = 1'b0;
  logic [7:0]  m_page   = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] mk(input logic s, input logic p, input logic w,
                                     input logic r, input logic a, input logic [7:0] d);
    return {s, p, w, r, a, d};
  endfunction

  // Bench-side expectation of the bus traffic and response for one access.
  task automatic expect_xfer(input logic rw, input logic [15:0] addr, input logic [7:0] wdata,
                             input logic [7:0] rdata, input logic nack_reg);
    if (!m_vld || m_page != addr[15:8]) begin
      cmd_q.push_back(mk(1, 0, 1, 0, 0, SA_W));
      cmd_q.push_back(mk(0, 0, 1, 0, 0, PGR));
      cmd_q.push_back(mk(0, 1, 1, 0, 0, addr[15:8]));
      m_vld  = 1'b1;
      m_page = addr[15:8];
    end
    cmd_q.push_back(mk(1, 0, 1, 0, 0, SA_W));
    cmd_q.push_back(mk(0, 0, 1, 0, 0, addr[7:0]));
    if (nack_reg) begin
      cmd_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
      rsp_q.push_back({1'b1, 1'b0, 8'h00});
      m_vld = 1'b0;
    end else if (!rw) begin
      cmd_q.push_back(mk(0, 1, 1, 0, 0, wdata));
      rsp_q.push_back({1'b0, 1'b0, 8'h00});
    end else begin
      cmd_q.push_back(mk(1, 0, 1, 0, 0, SA_R));
      cmd_q.push_back(mk(0, 1, 0, 1, 1, 8'h00));
      rsp_q.push_back({1'b0, 1'b1, rdata});
    end
  endtask

  // Byte-master model and scoreboard consumer.
  initial begin
    int         lat;
    int         nack_used;
    int         stray_done;
    logic       busy;
    logic       give_nack;
    logic [7:0] held_din;
    logic [12:0] obs;
    logic [9:0]  r;
    cmd_ack_i = 1'b0;
    ack_out_i = 1'b0;
    dout_i    = 8'h00;
    busy = 1'b0; give_nack = 1'b0; held_din = 8'h00;
    lat = 0; nack_used = 0; stray_done = 0;
    forever begin
      @(negedge clk_i);
      cmd_ack_i = 1'b0;
      ack_out_i = 1'b0;
      if (!arstn_i) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          check("din_hold", 32'(din_o), 32'(held_din));
          lat--;
          if (lat == 0) begin
            cmd_ack_i = 1'b1;
            ack_out_i = give_nack;
            dout_i    = rd_val;
            busy      = 1'b0;
          end
        end else if (stray_req != stray_done) begin
          stray_done++;
          cmd_ack_i = 1'b1;
          ack_out_i = 1'b1;
          dout_i    = 8'hFF;
        end
        if (start_o || stop_o || write_o || read_o) begin
          obs = {start_o, stop_o, write_o, read_o, ack_in_o, din_o};
          if (busy) check("cmd_overlap", 32'(obs), 32'(0));
          if (cmd_q.size() == 0) check("cmd_unexpected", 32'(obs), 32'(0));
          else check("cmd_byte", 32'(obs), 32'(cmd_q.pop_front()));
          give_nack = 1'b0;
          if (nack_req != nack_used && write_o && din_o == nack_din) begin
            give_nack = 1'b1;
            nack_used++;
          end
          busy     = 1'b1;
          held_din = din_o;
          lat      = $urandom_range(1, 3);
        end
        if (rsp_valid_o) begin
          if (rsp_q.size() == 0) begin
            check("rsp_unexpected", 32'(1), 32'(0));
          end else begin
            r = rsp_q.pop_front();
            check("rsp_err", 32'(rsp_err_o), 32'(r[9]));
            if (r[8]) check("rsp_rdata", 32'(rsp_rdata_o), 32'(r[7:0]));
          end
        end
      end
    end
  end

  task automatic send(input logic rw, input logic [15:0] addr, input logic [7:0] wdata);
    int n;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_rw_i    = rw;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    n = 0;
    while (!req_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) check("req_ready_timeout", 32'(0), 32'(1));
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || cmd_q.size() != 0) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 2000) check("xfer_timeout", 32'(rsp_q.size() + cmd_q.size()), 32'(0));
    @(negedge clk_i);
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({start_o, stop_o, write_o, read_o, ack_in_o, rsp_valid_o, rsp_err_o, din_o, rsp_rdata_o});
  endfunction

  initial begin
    int n;
    int ready_hi;
    arstn_i     = 1'b0;
    req_valid_i = 1'b0;
    req_rw_i    = 1'b0;
    req_addr_i  = 16'h0000;
    req_wdata_i = 8'h00;
    repeat (3) @(negedge clk_i);
    check("rst_outputs_init", out_vec(), 32'(0));
    arstn_i = 1'b1;
    @(negedge clk_i);
    check("ready_idle", 32'(req_ready_o), 32'(1));

    // Page miss after reset, then a page hit on the same page
    expect_xfer(1'b0, 16'h0B24, 8'h5A, 8'h00, 1'b0);
    send(1'b0, 16'h0B24, 8'h5A);
    wait_done();
    expect_xfer(1'b0, 16'h0B25, 8'h11, 8'h00, 1'b0);
    send(1'b0, 16'h0B25, 8'h11);
    wait_done();

    // Unsolicited acknowledge while idle must not start anything
    stray_req++;
    repeat (4) @(negedge clk_i);
    check("stray_ready", 32'(req_ready_o), 32'(1));

    rd_val = 8'h34;
    expect_xfer(1'b1, 16'h0B02, 8'h00, 8'h34, 1'b0);
    send(1'b1, 16'h0B02, 8'h00);
    wait_done();

    // NACK on the register byte, then the page must be rewritten
    nack_din = 8'h30;
    nack_req++;
    expect_xfer(1'b0, 16'h0B30, 8'h77, 8'h00, 1'b1);
    send(1'b0, 16'h0B30, 8'h77);
    wait_done();
    check("rdata_held", 32'(rsp_rdata_o), 32'(8'h34));
    rd_val = 8'h5C;
    expect_xfer(1'b1, 16'h0B31, 8'h00, 8'h5C, 1'b0);
    send(1'b1, 16'h0B31, 8'h00);
    wait_done();

    expect_xfer(1'b0, 16'h0C10, 8'hA5, 8'h00, 1'b0);
    send(1'b0, 16'h0C10, 8'hA5);
    wait_done();

    // Reset while the data byte is outstanding
    expect_xfer(1'b0, 16'h0C11, 8'h99, 8'h00, 1'b0);
    send(1'b0, 16'h0C11, 8'h99);
    n = 0;
    while (!(write_o && stop_o && din_o == 8'h99) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("wdat_reached", 32'(n < 500), 32'(1));
    @(negedge clk_i);
    arstn_i = 1'b0;
    #1;
    check("rst_outputs_mid", out_vec(), 32'(0));
    cmd_q.delete();
    rsp_q.delete();
    m_vld = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_outputs_hold", out_vec(), 32'(0));
    arstn_i = 1'b1;
    @(negedge clk_i);
    expect_xfer(1'b0, 16'h0C12, 8'h3C, 8'h00, 1'b0);
    send(1'b0, 16'h0C12, 8'h3C);
    wait_done();

    // Back-to-back requests with valid held high
    rd_val = 8'h7E;
    expect_xfer(1'b0, 16'h0C20, 8'h01, 8'h00, 1'b0);
    expect_xfer(1'b1, 16'h0C21, 8'h00, 8'h7E, 1'b0);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_rw_i    = 1'b0;
    req_addr_i  = 16'h0C20;
    req_wdata_i = 8'h01;
    check("b2b_ready_first", 32'(req_ready_o), 32'(1));
    @(negedge clk_i);
    req_rw_i    = 1'b1;
    req_addr_i  = 16'h0C21;
    req_wdata_i = 8'h00;
    ready_hi = 0;
    n = 0;
    while (!rsp_valid_o && n < 500) begin
      if (req_ready_o) ready_hi++;
      @(negedge clk_i);
      n++;
    end
    check("b2b_rsp_seen", 32'(rsp_valid_o), 32'(1));
    check("b2b_ready_low", 32'(ready_hi), 32'(0));
    check("b2b_ready_at_rsp", 32'(req_ready_o), 32'(0));
    @(negedge clk_i);
    check("b2b_ready_after", 32'(req_ready_o), 32'(1));
    @(negedge clk_i);
    check("b2b_accepted", 32'(req_ready_o), 32'(0));
    req_valid_i = 1'b0;
    wait_done();
    check("rdata_final", 32'(rsp_rdata_o), 32'(8'h7E));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
